mac_accumulator: RTL and testbench

Sequential multiply-accumulate stage that sits directly downstream of the team's combinational 4x4 array multiplier (`multiply`). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and feeds each pair through an internal `multiply` instance. It sums `N_TERMS` consecutive 8-bit products into an accumulator and presents the dot-product result on a second valid/ready handshake. It flags any result that exceeded the accumulator width.

---
 rtl/mac_accumulator.sv | 110 +++++++++++
 tb/tb_mac_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: sums N_TERMS 4x4 products per result over valid/ready handshakes.
// Optional build macro MAC_SATURATE_EN clamps the accumulator at 2^ACC_W-1 instead of wrapping.

module multiply (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] pp [4];

    // One shifted partial-product row per multiplier bit, summed as an array.
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign pp[i] = {4'b0000, a & {4{b[i]}}} << i;
    end

    assign p = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module mac_accumulator #(
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic {S_ACC, S_HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [7:0]       prod;
    logic [ACC_W:0]   sum;

    multiply u_mul (.a(a), .b(b), .p(prod));

    // Extra top bit catches the carry out of the accumulator width.
    assign sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_HOLD);
    assign acc_out   = acc;
    assign overflow  = ovf;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clear) begin
            state_nxt = S_ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (in_valid) begin
                        ovf_nxt = ovf | sum[ACC_W];
`ifdef MAC_SATURATE_EN
                        acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                        acc_nxt = sum[ACC_W-1:0];
`endif
                        if (cnt == LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = S_HOLD;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        state_nxt = S_ACC;
                    end
                end
                default: state_nxt = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: three configurations share one stimulus stream, each with its own
// dot-product reference model and output monitor.

module tb_mac_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Result of a full dot product given its exact integer sum.
    function automatic exp_t mk_exp(input int s, input int w);
        exp_t e;
        int   mx;
        mx    = (1 << w) - 1;
        e.ovf = (s > mx);
`ifdef MAC_SATURATE_EN
        e.acc = (s > mx) ? mx : s;
`else
        e.acc = s % (1 << w);
`endif
        return e;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W = (k == 1) ? 8 : 12;
        localparam int N = (k == 0) ? 4 : ((k == 1) ? 2 : 1);

        logic         in_ready, out_valid, overflow;
        logic [W-1:0] acc_out;

        mac_accumulator #(.ACC_W(W), .N_TERMS(N)) dut (
            .clk(clk), .rst_n(rst_n), .clear(clear),
            .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
            .out_valid(out_valid), .out_ready(out_ready),
            .acc_out(acc_out), .overflow(overflow)
        );

        exp_t q[$];
        int   sum  = 0;
        int   cnt  = 0;
        bit   hold = 1'b0;

        // Reference model: exact integer sum of products, result pushed when complete.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                sum  = 0;
                cnt  = 0;
                hold = 1'b0;
            end else if (clear) begin
                if (hold) void'(q.pop_front());
                sum  = 0;
                cnt  = 0;
                hold = 1'b0;
            end else if (hold) begin
                if (out_ready) begin
                    void'(q.pop_front());
                    sum  = 0;
                    hold = 1'b0;
                end
            end else if (in_valid) begin
                sum += int'(a) * int'(b);
                cnt++;
                if (cnt == N) begin
                    q.push_back(mk_exp(sum, W));
                    cnt  = 0;
                    hold = 1'b1;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (rst_n) begin
                check($sformatf("u%0d.in_ready", k), int'(in_ready), int'(!hold));
                check($sformatf("u%0d.out_valid", k), int'(out_valid), int'(hold));
                if (out_valid && hold && q.size() > 0) begin
                    check($sformatf("u%0d.acc_out", k), int'(acc_out), q[0].acc);
                    check($sformatf("u%0d.overflow", k), int'(overflow), int'(q[0].ovf));
                end
            end
        end
    end

    task automatic send(input int x, input int y);
        in_valid = 1'b1;
        a = 4'(x);
        b = 4'(y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst u0.in_ready", int'(g[0].in_ready), 1);
        check("rst u0.out_valid", int'(g[0].out_valid), 0);
        check("rst u0.acc_out", int'(g[0].acc_out), 0);
        check("rst u0.overflow", int'(g[0].overflow), 0);
        check("rst u1.acc_out", int'(g[1].acc_out), 0);
        check("rst u2.in_ready", int'(g[2].in_ready), 1);
        rst_n = 1'b1;

        // Two maximal products overflow the 8-bit accumulator.
        out_ready = 1'b0;
        send(15, 15);
        send(15, 15);
        @(negedge clk);
        check("ovf u1.out_valid", int'(g[1].out_valid), 1);
`ifdef MAC_SATURATE_EN
        check("ovf u1.acc_out", int'(g[1].acc_out), 255);
`else
        check("ovf u1.acc_out", int'(g[1].acc_out), 194);
`endif
        check("ovf u1.overflow", int'(g[1].overflow), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;

        // Basic dot product.
        out_ready = 1'b1;
        send(3, 5); send(2, 7); send(15, 15); send(0, 9);
        @(negedge clk);
        check("dot u0.out_valid", int'(g[0].out_valid), 1);
        check("dot u0.acc_out", int'(g[0].acc_out), 254);
        check("dot u0.overflow", int'(g[0].overflow), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("dot u0.in_ready after", int'(g[0].in_ready), 1);
        check("dot u0.out_valid after", int'(g[0].out_valid), 0);
        @(posedge clk);
        #1;

        // Backpressure: result held while the consumer stalls.
        out_ready = 1'b0;
        repeat (4) send(1, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 4'd1; b = 4'd1;
            @(negedge clk);
            check("bp u0.in_ready", int'(g[0].in_ready), 0);
            check("bp u0.acc_out", int'(g[0].acc_out), 4);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) send(2, 3);
        @(negedge clk);
        check("bp u0.next", int'(g[0].acc_out), 24);
        @(posedge clk);
        #1;

        // Clear wins over a simultaneous accept, and discards a held result.
        send(4, 4); send(4, 4);
        in_valid = 1'b1; a = 4'd4; b = 4'd4; clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (4) send(1, 2);
        @(negedge clk);
        check("clr u0.acc_out", int'(g[0].acc_out), 8);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr u0.out_valid", int'(g[0].out_valid), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset between edges.
        send(2, 3); send(2, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst u0.acc_out", int'(g[0].acc_out), 0);
        check("arst u0.out_valid", int'(g[0].out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) send(2, 3);
        @(negedge clk);
        check("arst u0.result", int'(g[0].acc_out), 24);
        @(posedge clk);
        #1;

        // Single-term configuration with in_valid held high.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b1; a = 4'd15; b = 4'd14;
        @(posedge clk);
        #1;
        a = 4'd7; b = 4'd7;
        @(negedge clk);
        check("n1 u2.acc_out 1st", int'(g[2].acc_out), 210);
        check("n1 u2.in_ready 0", int'(g[2].in_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("n1 u2.in_ready 1", int'(g[2].in_ready), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("n1 u2.acc_out 2nd", int'(g[2].acc_out), 49);
        check("n1 u2.in_ready 0b", int'(g[2].in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Randomised traffic, scoreboard does the checking.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = 4'($urandom);
            b         = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 40) == 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
